// File: rtl/matmul_pkg.sv
// +------------------------------------------------------------------+
// | matmul_pkg: shared types, polynomials and width helpers           |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_RES = 3'd2,
      ST_CHECK    = 3'd3,
      ST_DONE     = 3'd4
   } selftest_state_e;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

   // Right-shifting Galois LFSR: the bit shifted out selects the tap mask.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic int selftest_cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_misr.sv
// +------------------------------------------------------------------+
// | matmul_misr: multiple-input signature register, all-ones seed     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module matmul_misr
   import matmul_pkg::*;
#(
   parameter int                   SIG_WIDTH = 32,
   parameter int                   IN_WIDTH  = 16,
   parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(MISR_POLY)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_en,
   input  logic [IN_WIDTH-1:0]  i_data,
   output logic [SIG_WIDTH-1:0] o_sig
);

   logic [SIG_WIDTH-1:0] r_sig;
   logic [SIG_WIDTH-1:0] w_sig_nxt;

   always_comb begin
      w_sig_nxt = {r_sig[SIG_WIDTH-2:0], 1'b0}
                ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                ^ SIG_WIDTH'(i_data);
   end

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_sig <= '1;
      end else if (i_en) begin
         r_sig <= w_sig_nxt;
      end
   end

   assign o_sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/matmul_selftest.sv
// +------------------------------------------------------------------+
// | matmul_selftest: BIST sequencer streaming operands to the matmul  |
// | core and signing its results with a MISR. Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module matmul_selftest
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DIM         = 4,
   parameter int NUM_RUNS    = 4,
   parameter int SIG_WIDTH   = 32,
   parameter int TIMEOUT_CYC = 1024,
   parameter int RES_WIDTH   = 2*DATA_WIDTH + $clog2(DIM)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic                                  abort_i,
   input  logic                                  mode_i,
   input  logic [31:0]                           seed_i,
   output logic                                  stim_valid_o,
   input  logic                                  stim_ready_i,
   output logic [DATA_WIDTH-1:0]                 stim_a_o,
   output logic [DATA_WIDTH-1:0]                 stim_b_o,
   output logic                                  stim_last_o,
   input  logic                                  res_valid_i,
   input  logic [RES_WIDTH-1:0]                  res_data_i,
   input  logic                                  res_last_i,
   output logic [selftest_cnt_w(NUM_RUNS)-1:0]   run_idx_o,
   input  logic [SIG_WIDTH-1:0]                  exp_sig_i,
   output logic [SIG_WIDTH-1:0]                  sig_o,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  pass_o,
   output logic [selftest_cnt_w(NUM_RUNS)-1:0]   fail_cnt_o
);

   localparam int NBEATS = DIM * DIM;
   localparam int BW     = selftest_cnt_w(NBEATS) + 1;
   localparam int TW     = selftest_cnt_w(TIMEOUT_CYC);
   localparam int RW     = selftest_cnt_w(NUM_RUNS);

   selftest_state_e r_state, w_state_nxt;

   logic                  r_mode, w_mode_nxt;
   logic [31:0]           r_lfsr, w_lfsr_nxt, w_seed;
   logic [BW-1:0]         r_beat, w_beat_nxt, r_res_cnt;
   logic [TW-1:0]         r_tmo;
   logic                  r_run_err, r_pass, r_stim_last;
   logic [DATA_WIDTH-1:0] r_stim_a, r_stim_b;
   logic [RW-1:0]         r_run_idx, r_fail_cnt;
   logic [SIG_WIDTH-1:0]  r_sig, w_misr_sig;
   logic [2*DATA_WIDTH-1:0] w_ops;
   logic                  w_start, w_hs, w_res_acc, w_load_entry, w_tmo_hit;
   logic                  w_run_fail, w_last_run;

   function automatic logic [2*DATA_WIDTH-1:0] operands(input logic mode,
                                                        input logic [31:0] lfsr,
                                                        input logic [BW-1:0] beat);
      logic [DATA_WIDTH-1:0] a, b;
      a = '0;
      b = '0;
      if (mode) begin
         a = DATA_WIDTH'(beat);
         b = ~a;
      end else begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            a[i] = lfsr[5'(i % 32)];
            b[i] = lfsr[5'((i + DATA_WIDTH) % 32)];
         end
      end
      return {a, b};
   endfunction

   assign w_start      = (r_state == ST_IDLE) && start_i && !abort_i;
   assign w_hs         = (r_state == ST_LOAD) && stim_ready_i;
   assign w_res_acc    = res_valid_i && ((r_state == ST_LOAD) || (r_state == ST_WAIT_RES));
   assign w_load_entry = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
   assign w_tmo_hit    = (r_state == ST_WAIT_RES) && (r_tmo == TW'(TIMEOUT_CYC - 1))
                         && (r_res_cnt < BW'(NBEATS));
   assign w_run_fail   = r_run_err || (w_misr_sig != exp_sig_i) || res_valid_i;
   assign w_last_run   = (r_run_idx == RW'(NUM_RUNS - 1));

   always_comb begin
      w_state_nxt  = r_state;
      stim_valid_o = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      case (r_state)
         ST_IDLE:     if (start_i) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            stim_valid_o = 1'b1;
            busy_o       = 1'b1;
            if (w_hs && r_stim_last) w_state_nxt = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            busy_o = 1'b1;
            if ((r_res_cnt >= BW'(NBEATS)) || (r_tmo == TW'(TIMEOUT_CYC - 1)))
               w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            busy_o      = 1'b1;
            w_state_nxt = w_last_run ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:     w_state_nxt = ST_IDLE;
      endcase
      if (abort_i) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Operand registers are reloaded from the next LFSR/beat values, so the
   // presented operand always reflects the current r_lfsr/r_beat pair.
   always_comb begin
      w_seed = (seed_i == 32'd0) ? 32'd1 : seed_i;
      if (w_start) begin
         w_lfsr_nxt = lfsr_step(w_seed);
         w_beat_nxt = '0;
         w_mode_nxt = mode_i;
      end else begin
         w_lfsr_nxt = lfsr_step(r_lfsr);
         w_beat_nxt = (r_beat == BW'(NBEATS - 1)) ? '0 : r_beat + BW'(1);
         w_mode_nxt = r_mode;
      end
      w_ops = operands(w_mode_nxt, w_lfsr_nxt, w_beat_nxt);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mode      <= 1'b0;
         r_lfsr      <= 32'd1;
         r_beat      <= '0;
         r_stim_a    <= '0;
         r_stim_b    <= '0;
         r_stim_last <= 1'b0;
         r_res_cnt   <= '0;
         r_tmo       <= '0;
         r_run_err   <= 1'b0;
         r_run_idx   <= '0;
         r_fail_cnt  <= '0;
         r_sig       <= '0;
         r_pass      <= 1'b0;
      end else begin
         if (w_start || w_hs) begin
            r_mode      <= w_mode_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_beat      <= w_beat_nxt;
            r_stim_a    <= w_ops[2*DATA_WIDTH-1:DATA_WIDTH];
            r_stim_b    <= w_ops[DATA_WIDTH-1:0];
            r_stim_last <= (w_beat_nxt == BW'(NBEATS - 1));
         end
         if (w_start) begin
            r_run_idx  <= '0;
            r_fail_cnt <= '0;
            r_pass     <= 1'b0;
         end
         r_tmo <= (r_state == ST_WAIT_RES) ? r_tmo + TW'(1) : '0;
         if (w_load_entry) begin
            r_res_cnt <= '0;
            r_run_err <= 1'b0;
         end else begin
            if (w_res_acc) begin
               r_res_cnt <= r_res_cnt + BW'(1);
               if (res_last_i != (r_res_cnt == BW'(NBEATS - 1))) r_run_err <= 1'b1;
            end
            if (w_tmo_hit) r_run_err <= 1'b1;
         end
         if ((r_state == ST_CHECK) && !abort_i) begin
            r_sig      <= w_misr_sig;
            r_fail_cnt <= r_fail_cnt + RW'(w_run_fail);
            if (w_last_run) r_pass    <= (r_fail_cnt == '0) && !w_run_fail;
            else            r_run_idx <= r_run_idx + RW'(1);
         end
      end
   end

   matmul_misr #(
      .SIG_WIDTH (SIG_WIDTH),
      .IN_WIDTH  (RES_WIDTH)
   ) u_misr (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_clear (w_load_entry),
      .i_en    (w_res_acc),
      .i_data  (res_data_i),
      .o_sig   (w_misr_sig)
   );

   assign stim_a_o    = r_stim_a;
   assign stim_b_o    = r_stim_b;
   assign stim_last_o = r_stim_last;
   assign run_idx_o   = r_run_idx;
   assign fail_cnt_o  = r_fail_cnt;
   assign sig_o       = r_sig;
   assign pass_o      = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_matmul_selftest.sv
// +------------------------------------------------------------------+
// | tb_matmul_selftest: directed bench for matmul_selftest (DIM=2)    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_matmul_selftest;

   logic        clk = 1'b0;
   logic        rst_i, start_i, abort_i, mode_i;
   logic [31:0] seed_i;
   logic        stim_valid_o, stim_ready_i, stim_last_o;
   logic [7:0]  stim_a_o, stim_b_o;
   logic        res_valid_i, res_last_i;
   logic [16:0] res_data_i;
   logic [2:0]  run_idx_o, fail_cnt_o;
   logic [31:0] exp_sig_i, sig_o;
   logic        busy_o, done_o, pass_o;

   int checks = 0;
   int errors = 0;

   // C = A*B with A = [[0,1],[2,3]], B = [[255,254],[253,252]]
   logic [16:0] gold_res[4] = '{17'd253, 17'd252, 17'd1269, 17'd1264};
   logic [7:0]  pat_a[4]    = '{8'h00, 8'h01, 8'h02, 8'h03};
   logic [7:0]  pat_b[4]    = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
   logic [31:0] exp_tab[4];
   logic [31:0] gold_sig;
   logic [31:0] sig_hist[4];
   logic [7:0]  cap_a[64], cap_b[64];
   logic        cap_last[64];
   int          n_cap;

   always #5 clk = ~clk;

   always_comb begin
      exp_sig_i = 32'h0;
      if (run_idx_o < 3'd4) exp_sig_i = exp_tab[run_idx_o[1:0]];
   end

   matmul_selftest #(
      .DATA_WIDTH  (8),
      .DIM         (2),
      .NUM_RUNS    (4),
      .SIG_WIDTH   (32),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .mode_i       (mode_i),
      .seed_i       (seed_i),
      .stim_valid_o (stim_valid_o),
      .stim_ready_i (stim_ready_i),
      .stim_a_o     (stim_a_o),
      .stim_b_o     (stim_b_o),
      .stim_last_o  (stim_last_o),
      .res_valid_i  (res_valid_i),
      .res_data_i   (res_data_i),
      .res_last_i   (res_last_i),
      .run_idx_o    (run_idx_o),
      .exp_sig_i    (exp_sig_i),
      .sig_o        (sig_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pass_o       (pass_o),
      .fail_cnt_o   (fail_cnt_o)
   );

   function automatic logic [31:0] misr_ref();
      logic [31:0] s;
      s = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++)
         s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {15'h0, gold_res[i]};
      return s;
   endfunction

   // res_mode: 0 = golden results, 1 = none, 2 = golden with res_last on beat 2 of special_run
   task automatic run_sequence(input logic mode, input logic [31:0] seed, input bit rand_ready,
                               input int res_mode, input int special_run,
                               output int busy_cyc, output bit done_seen);
      int cyc, run_no, res_left, res_idx, res_run;
      logic pv, pr, pl;
      logic [7:0] pa, pb;
      n_cap = 0; busy_cyc = 0; done_seen = 0; run_no = 0;
      res_left = 0; res_idx = 0; res_run = 0; cyc = 0;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = 8'h0; pb = 8'h0;
      @(negedge clk);
      mode_i = mode; seed_i = seed; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      mode_i  = ~mode;
      while (!done_seen && cyc < 2000) begin
         start_i = (cyc == 7);
         if (done_o) begin
            done_seen = 1'b1;
            if (run_no > 0 && run_no <= 4) sig_hist[run_no-1] = sig_o;
         end else begin
            if (busy_o) busy_cyc++;
            if (stim_valid_o && !pv && run_no > 0 && run_no <= 4) sig_hist[run_no-1] = sig_o;
            if (pv && !pr && stim_valid_o) begin
               checks++;
               if ({stim_a_o, stim_b_o, stim_last_o} !== {pa, pb, pl}) begin
                  errors++;
                  $display("FAIL stall_hold got %h/%h/%b want %h/%h/%b",
                           stim_a_o, stim_b_o, stim_last_o, pa, pb, pl);
               end
            end
            if (res_left > 0) begin
               res_valid_i = 1'b1;
               res_data_i  = gold_res[res_idx];
               res_last_i  = (res_mode == 2 && res_run == special_run) ? (res_idx == 2) : (res_idx == 3);
               res_idx++;
               res_left--;
            end else begin
               res_valid_i = 1'b0;
               res_last_i  = 1'b0;
               res_data_i  = '0;
            end
            stim_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stim_valid_o && stim_ready_i && n_cap < 64) begin
               cap_a[n_cap] = stim_a_o; cap_b[n_cap] = stim_b_o; cap_last[n_cap] = stim_last_o;
               n_cap++;
               if (stim_last_o) begin
                  if (res_mode != 1) begin res_left = 4; res_idx = 0; res_run = run_no; end
                  run_no++;
               end
            end
            pv = stim_valid_o; pr = stim_ready_i; pa = stim_a_o; pb = stim_b_o; pl = stim_last_o;
            @(negedge clk);
            cyc++;
         end
      end
      start_i = 1'b0; res_valid_i = 1'b0; res_last_i = 1'b0;
      if (!done_seen) begin
         errors++;
         $display("FAIL seq_timeout got no done_o want done_o within 2000 cycles");
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({stim_valid_o, busy_o, done_o, pass_o, stim_last_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000", {stim_valid_o, busy_o, done_o, pass_o, stim_last_o});
      end
      checks++;
      if ({run_idx_o, fail_cnt_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_counts got %h/%h want 0/0", run_idx_o, fail_cnt_o);
      end
      checks++;
      if ({sig_o, stim_a_o, stim_b_o} !== 48'h0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h want 0/0/0", sig_o, stim_a_o, stim_b_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_mode1_golden();
      int bc; bit dn;
      run_sequence(1'b1, 32'h1234_5678, 1'b0, 0, 0, bc, dn);
      checks++;
      if (n_cap !== 16) begin errors++; $display("FAIL golden_beats got %0d want 16", n_cap); end
      for (int i = 0; i < 16 && i < n_cap; i++) begin
         checks++;
         if (cap_a[i] !== pat_a[i%4] || cap_b[i] !== pat_b[i%4] || cap_last[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL golden_op%0d got %h/%h/%b want %h/%h/%b", i, cap_a[i], cap_b[i],
                     cap_last[i], pat_a[i%4], pat_b[i%4], (i % 4 == 3));
         end
      end
      checks++;
      if (bc !== 40) begin errors++; $display("FAIL golden_busy_cycles got %0d want 40", bc); end
      checks++;
      if (pass_o !== 1'b1 || fail_cnt_o !== 3'd0) begin
         errors++;
         $display("FAIL golden_status got pass=%b fails=%0d want pass=1 fails=0", pass_o, fail_cnt_o);
      end
      checks++;
      if (sig_o !== gold_sig) begin errors++; $display("FAIL golden_sig got %h want %h", sig_o, gold_sig); end
      checks++;
      if (run_idx_o !== 3'd3) begin errors++; $display("FAIL golden_run_idx got %0d want 3", run_idx_o); end
   endtask

   task automatic test_bad_signature();
      int bc; bit dn;
      exp_tab[2] = gold_sig ^ 32'h0000_0001;
      run_sequence(1'b1, 32'h1, 1'b0, 0, 0, bc, dn);
      exp_tab[2] = gold_sig;
      checks++;
      if (fail_cnt_o !== 3'd1 || pass_o !== 1'b0) begin
         errors++;
         $display("FAIL badsig_status got pass=%b fails=%0d want pass=0 fails=1", pass_o, fail_cnt_o);
      end
      checks++;
      if (sig_hist[2] !== gold_sig) begin
         errors++;
         $display("FAIL badsig_run2_sig got %h want %h", sig_hist[2], gold_sig);
      end
   endtask

   task automatic test_early_last();
      int bc; bit dn;
      run_sequence(1'b1, 32'h1, 1'b0, 2, 1, bc, dn);
      checks++;
      if (fail_cnt_o !== 3'd1 || pass_o !== 1'b0 || dn !== 1'b1) begin
         errors++;
         $display("FAIL early_last_status got pass=%b fails=%0d want pass=0 fails=1", pass_o, fail_cnt_o);
      end
      checks++;
      if (sig_hist[3] !== gold_sig) begin
         errors++;
         $display("FAIL early_last_next_run got %h want %h", sig_hist[3], gold_sig);
      end
   endtask

   task automatic test_timeout_lfsr();
      int bc; bit dn;
      run_sequence(1'b0, 32'h0, 1'b0, 1, 0, bc, dn);
      checks++;
      if (cap_a[0] !== 8'h03 || cap_b[0] !== 8'h00) begin
         errors++;
         $display("FAIL lfsr_first got %h/%h want 03/00", cap_a[0], cap_b[0]);
      end
      checks++;
      if ({cap_a[1], cap_a[2], cap_a[3], cap_a[4]} !== 32'h02_01_03_02) begin
         errors++;
         $display("FAIL lfsr_seq got %h %h %h %h want 02 01 03 02", cap_a[1], cap_a[2], cap_a[3], cap_a[4]);
      end
      checks++;
      if (bc !== 84) begin errors++; $display("FAIL timeout_busy_cycles got %0d want 84", bc); end
      checks++;
      if (fail_cnt_o !== 3'd4 || pass_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_status got pass=%b fails=%0d want pass=0 fails=4", pass_o, fail_cnt_o);
      end
      checks++;
      if (sig_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_sig got %h want ffffffff", sig_o); end
   endtask

   task automatic test_abort_restart();
      int bc; bit dn; bit hit;
      hit = 1'b0;
      @(negedge clk);
      stim_ready_i = 1'b1; mode_i = 1'b0; seed_i = 32'h0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (run_idx_o == 3'd1 && stim_valid_o) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL abort_reach_run1 got no run 1 want run 1 loading"); end
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      checks++;
      if ({busy_o, done_o, stim_valid_o} !== 3'b000 || fail_cnt_o !== 3'd1) begin
         errors++;
         $display("FAIL abort_state got busy/done/valid=%b fails=%0d want 000 fails=1",
                  {busy_o, done_o, stim_valid_o}, fail_cnt_o);
      end
      run_sequence(1'b0, 32'h0, 1'b1, 1, 0, bc, dn);
      checks++;
      if ({cap_a[0], cap_a[1], cap_a[2], cap_a[3], cap_a[4]} !== 40'h03_02_01_03_02) begin
         errors++;
         $display("FAIL abort_reseed got %h %h %h %h %h want 03 02 01 03 02",
                  cap_a[0], cap_a[1], cap_a[2], cap_a[3], cap_a[4]);
      end
      checks++;
      if (fail_cnt_o !== 3'd4 || dn !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart_runs got fails=%0d want 4", fail_cnt_o);
      end
   endtask

   task automatic test_reset_midrun();
      int bc; bit dn;
      run_sequence(1'b1, 32'h1, 1'b0, 0, 0, bc, dn);
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_o); end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", busy_o); end
      repeat (4) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      checks++;
      if ({busy_o, stim_valid_o, pass_o} !== 3'b000 || sig_o !== 32'h0 || run_idx_o !== 3'd0) begin
         errors++;
         $display("FAIL midrun_reset got busy/valid/pass=%b sig=%h run=%0d want 000 0 0",
                  {busy_o, stim_valid_o, pass_o}, sig_o, run_idx_o);
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; seed_i = 32'h0;
      stim_ready_i = 1'b0; res_valid_i = 1'b0; res_last_i = 1'b0; res_data_i = '0;
      gold_sig = misr_ref();
      for (int i = 0; i < 4; i++) begin exp_tab[i] = gold_sig; sig_hist[i] = 32'h0; end
      test_reset();
      test_mode1_golden();
      test_bad_signature();
      test_early_last();
      test_timeout_lfsr();
      test_abort_restart();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
